// File: rtl/id_ex_if.sv
// ID/EX stage bus: decode-side inputs and EX-side outputs of the ID/EX pipeline register.
// The stage uses the slave modport. The decode/driver side uses the master modport.
interface id_ex_if #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int CNT_W = 16
);
  // Decode side
  logic             in_valid;
  logic [PC_W-1:0]  pc_in;
  logic [XLEN-1:0]  ReadData1;
  logic [XLEN-1:0]  ReadData2;
  logic [XLEN-1:0]  imm_in;
  logic [4:0]       RS1;
  logic [4:0]       RS2;
  logic [4:0]       RD;
  logic [3:0]       funct4;
  logic [7:0]       ctrl_in;
  logic             flush;
  // Writeback side (consumed only when the bypass is built in)
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  // EX side
  logic             stall_out;
  logic             ex_valid;
  logic [PC_W-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic [3:0]       ex_funct4;
  logic [7:0]       ex_ctrl;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  in_valid, pc_in, ReadData1, ReadData2, imm_in, RS1, RS2, RD, funct4, ctrl_in,
           flush, wb_regwrite, wb_rd, wb_data,
    output stall_out, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct4, ex_ctrl, stall_count
  );

  modport master (
    output in_valid, pc_in, ReadData1, ReadData2, imm_in, RS1, RS2, RD, funct4, ctrl_in,
           flush, wb_regwrite, wb_rd, wb_data,
    input  stall_out, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct4, ex_ctrl, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 64-bit RISC-V core.
// Captures decoded operands/control, detects load-use hazards (same-cycle stall_out),
// inserts bubbles on flush / stall / empty decode slot, and counts load-use bubbles
// in a saturating counter.
// Optional feature: define WB_BYPASS_EN to forward a same-cycle writeback value into
// the captured rs1/rs2 operands.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int CNT_W = 16
) (
  input logic    clk,
  input logic    reset,
  id_ex_if.slave bus
);

  // ctrl_in packing: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
  localparam int MEM_READ_BIT = 6;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct4;
  } ex_data_t;

  logic             valid_q, valid_d;
  logic [7:0]       ctrl_q, ctrl_d;
  ex_data_t         data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;
  logic [XLEN-1:0]  op1, op2;

  // Load-use hazard: the load now in EX writes a register the decode instruction reads.
  assign stall = ~bus.flush & bus.in_valid & valid_q & ctrl_q[MEM_READ_BIT] &
                 (data_q.rd != 5'd0) &
                 ((data_q.rd == bus.RS1) | (data_q.rd == bus.RS2));

`ifdef WB_BYPASS_EN
  // Writeback forwarding covers a register written and read in the same cycle.
  always_comb begin
    op1 = bus.ReadData1;
    op2 = bus.ReadData2;
    if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.RS1) op1 = bus.wb_data;
    if (bus.wb_regwrite && bus.wb_rd != 5'd0 && bus.wb_rd == bus.RS2) op2 = bus.wb_data;
  end
`else
  assign op1 = bus.ReadData1;
  assign op2 = bus.ReadData2;
  logic unused_wb;
  assign unused_wb = ^{bus.wb_regwrite, bus.wb_rd, bus.wb_data};
`endif

  // Next-state selection: flush > load-use stall > empty slot > normal capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    valid_d = 1'b0;
    ctrl_d  = 8'd0;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      // Killed instruction: bubble, not counted.
    end else if (stall) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (bus.in_valid) begin
      valid_d         = 1'b1;
      ctrl_d          = bus.ctrl_in;
      data_d.pc       = bus.pc_in;
      data_d.rs1_data = op1;
      data_d.rs2_data = op2;
      data_d.imm      = bus.imm_in;
      data_d.rs1      = bus.RS1;
      data_d.rs2      = bus.RS2;
      data_d.rd       = bus.RD;
      data_d.funct4   = bus.funct4;
    end
  end

  // Pipeline register and stall counter, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= 8'd0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX-side outputs straight from the registers.
  assign bus.stall_out   = stall;
  assign bus.ex_valid    = valid_q;
  assign bus.ex_ctrl     = ctrl_q;
  assign bus.ex_pc       = data_q.pc;
  assign bus.ex_rs1_data = data_q.rs1_data;
  assign bus.ex_rs2_data = data_q.rs2_data;
  assign bus.ex_imm      = data_q.imm;
  assign bus.ex_rs1      = data_q.rs1;
  assign bus.ex_rs2      = data_q.rs2;
  assign bus.ex_rd       = data_q.rd;
  assign bus.ex_funct4   = data_q.funct4;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random stimulus,
// all compared against a behavioural model of the EX slot. A second instance with a
// 2-bit stall counter exercises saturation.
module tb_id_ex_stage;

  localparam logic [7:0] CTRL_LD  = 8'hD4; // RegWrite, MemRead, MemtoReg, ALUSrc
  localparam logic [7:0] CTRL_ADD = 8'h82; // RegWrite, ALUOp=10

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ex_if #(.CNT_W(16)) bus ();
  id_ex_if #(.CNT_W(2))  bus_sat ();

  id_ex_stage #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  id_ex_stage #(.CNT_W(2))  dut_sat (.clk(clk), .reset(reset), .bus(bus_sat.slave));

  assign bus_sat.in_valid    = bus.in_valid;
  assign bus_sat.pc_in       = bus.pc_in;
  assign bus_sat.ReadData1   = bus.ReadData1;
  assign bus_sat.ReadData2   = bus.ReadData2;
  assign bus_sat.imm_in      = bus.imm_in;
  assign bus_sat.RS1         = bus.RS1;
  assign bus_sat.RS2         = bus.RS2;
  assign bus_sat.RD          = bus.RD;
  assign bus_sat.funct4      = bus.funct4;
  assign bus_sat.ctrl_in     = bus.ctrl_in;
  assign bus_sat.flush       = bus.flush;
  assign bus_sat.wb_regwrite = bus.wb_regwrite;
  assign bus_sat.wb_rd       = bus.wb_rd;
  assign bus_sat.wb_data     = bus.wb_data;

  // Reference model: contents of the EX slot and the two bubble counts.
  typedef struct {
    bit          valid;
    logic [63:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  f4;
    logic [7:0]  ctrl;
  } slot_t;

  slot_t       m;
  int unsigned cnt, cnt_sat;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m       = '{default: '0};
    cnt     = 0;
    cnt_sat = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".stall_out"}, 64'(bus.stall_out), 64'd0);
    check({tag, ".ex_valid"}, 64'(bus.ex_valid), 64'd0);
    check({tag, ".ex_ctrl"}, 64'(bus.ex_ctrl), 64'd0);
    check({tag, ".ex_pc"}, bus.ex_pc, 64'd0);
    check({tag, ".ex_rs1_data"}, bus.ex_rs1_data, 64'd0);
    check({tag, ".ex_rs2_data"}, bus.ex_rs2_data, 64'd0);
    check({tag, ".ex_imm"}, bus.ex_imm, 64'd0);
    check({tag, ".ex_idx"}, 64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct4}), 64'd0);
    check({tag, ".stall_count"}, 64'(bus.stall_count), 64'd0);
    check({tag, ".sat_count"}, 64'(bus_sat.stall_count), 64'd0);
  endtask

  task automatic set_instr(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [7:0] ctrl, input bit fl);
    bus.in_valid = v;
    bus.RS1      = rs1;
    bus.RS2      = rs2;
    bus.RD       = rd;
    bus.ctrl_in  = ctrl;
    bus.flush    = fl;
    bus.pc_in    = {$urandom, $urandom};
    bus.ReadData1 = {$urandom, $urandom};
    bus.ReadData2 = {$urandom, $urandom};
    bus.imm_in   = {$urandom, $urandom};
    bus.funct4   = 4'($urandom);
  endtask

  // One clock: check the combinational stall, clock, advance the model, check registers.
  task automatic step(input string tag);
    bit exp_stall;
    @(negedge clk);
    #1;
    exp_stall = !bus.flush && bus.in_valid && m.valid && m.ctrl[6] && m.rd != 0 &&
                (m.rd == bus.RS1 || m.rd == bus.RS2);
    check({tag, ".stall_out"}, 64'(bus.stall_out), 64'(exp_stall));
    @(posedge clk);
    if (bus.flush || exp_stall || !bus.in_valid) begin
      m.valid = 0;
      m.ctrl  = 0;
      if (exp_stall) begin
        cnt     = (cnt < 65535) ? cnt + 1 : cnt;
        cnt_sat = (cnt_sat < 3) ? cnt_sat + 1 : cnt_sat;
      end
    end else begin
      m.valid = 1;
      m.ctrl  = bus.ctrl_in;
      m.pc    = bus.pc_in;
      m.rs1d  = bus.ReadData1;
      m.rs2d  = bus.ReadData2;
`ifdef WB_BYPASS_EN
      if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == bus.RS1) m.rs1d = bus.wb_data;
      if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == bus.RS2) m.rs2d = bus.wb_data;
`endif
      m.imm = bus.imm_in;
      m.rs1 = bus.RS1;
      m.rs2 = bus.RS2;
      m.rd  = bus.RD;
      m.f4  = bus.funct4;
    end
    #1;
    check({tag, ".ex_valid"}, 64'(bus.ex_valid), 64'(m.valid));
    check({tag, ".ex_ctrl"}, 64'(bus.ex_ctrl), 64'(m.ctrl));
    check({tag, ".stall_count"}, 64'(bus.stall_count), 64'(cnt));
    check({tag, ".sat_count"}, 64'(bus_sat.stall_count), 64'(cnt_sat));
    if (m.valid) begin
      check({tag, ".ex_pc"}, bus.ex_pc, m.pc);
      check({tag, ".ex_rs1_data"}, bus.ex_rs1_data, m.rs1d);
      check({tag, ".ex_rs2_data"}, bus.ex_rs2_data, m.rs2d);
      check({tag, ".ex_imm"}, bus.ex_imm, m.imm);
      check({tag, ".ex_idx"}, 64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct4}),
            64'({m.rs1, m.rs2, m.rd, m.f4}));
    end
  endtask

  initial begin
    logic [63:0] exp_byp;
    int unsigned cnt_before;

    // Reset held from time zero with busy inputs.
    model_reset();
    set_instr(1, 5'd1, 5'd2, 5'd3, 8'hFF, 0);
    bus.wb_regwrite = 0;
    bus.wb_rd       = 0;
    bus.wb_data     = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_init");
    @(negedge clk);
    reset = 1'b1;

    // Normal capture.
    set_instr(1, 5'd1, 5'd2, 5'd3, 8'h81, 0);
    bus.pc_in     = 64'h100;
    bus.ReadData1 = 64'd5;
    step("normal");
    check("normal.pc_const", bus.ex_pc, 64'h100);
    check("normal.rs1_const", bus.ex_rs1_data, 64'd5);
    check("normal.ctrl_const", 64'(bus.ex_ctrl), 64'h81);

    // Load-use: ld x5 ; add x6,x5,x7 -> one stall, then add captured.
    set_instr(1, 5'd1, 5'd0, 5'd5, CTRL_LD, 0);
    step("ld_x5");
    set_instr(1, 5'd5, 5'd7, 5'd6, CTRL_ADD, 0);
    step("use_stall");
    check("use_stall.ex_valid0", 64'(bus.ex_valid), 64'd0);
    check("use_stall.count1", 64'(bus.stall_count), 64'd1);
    step("use_capture");
    check("use_capture.rd6", 64'(bus.ex_rd), 64'd6);

    // ld x0 followed by a use of x0 never stalls.
    set_instr(1, 5'd1, 5'd0, 5'd0, CTRL_LD, 0);
    step("ld_x0");
    set_instr(1, 5'd0, 5'd0, 5'd6, CTRL_ADD, 0);
    step("use_x0");
    check("use_x0.count", 64'(bus.stall_count), 64'd1);

    // Flush in the same cycle as a load-use match: bubble, not counted.
    set_instr(1, 5'd1, 5'd0, 5'd5, CTRL_LD, 0);
    step("ld_flush");
    set_instr(1, 5'd2, 5'd5, 5'd6, CTRL_ADD, 1);
    step("flush_hazard");
    check("flush_hazard.count", 64'(bus.stall_count), 64'd1);

    // Saturation: five load-use pairs.
    for (int i = 0; i < 5; i++) begin
      set_instr(1, 5'd0, 5'd0, 5'd9, CTRL_LD, 0);
      step("sat_ld");
      set_instr(1, 5'd9, 5'd1, 5'd4, CTRL_ADD, 0);
      step("sat_stall");
      step("sat_capture");
    end
    check("sat.count3", 64'(bus_sat.stall_count), 64'd3);
    check("sat.count_wide", 64'(bus.stall_count), 64'd6);

    // Writeback bypass.
`ifdef WB_BYPASS_EN
    exp_byp = 64'hAA;
`else
    exp_byp = 64'h11;
`endif
    set_instr(1, 5'd3, 5'd8, 5'd4, CTRL_ADD, 0);
    bus.ReadData1   = 64'h11;
    bus.wb_regwrite = 1;
    bus.wb_rd       = 5'd3;
    bus.wb_data     = 64'hAA;
    step("bypass");
    check("bypass.rs1_const", bus.ex_rs1_data, exp_byp);
    set_instr(1, 5'd0, 5'd8, 5'd4, CTRL_ADD, 0);
    bus.ReadData1 = 64'h11;
    bus.wb_rd     = 5'd0;
    step("bypass_x0");
    check("bypass_x0.rs1_const", bus.ex_rs1_data, 64'h11);

    // Random traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_instr($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                ($urandom_range(0, 1) != 0) ? CTRL_LD : 8'($urandom),
                $urandom_range(0, 9) == 0);
      bus.wb_regwrite = 1'($urandom);
      bus.wb_rd       = 5'($urandom_range(0, 3));
      bus.wb_data     = {$urandom, $urandom};
      step("random");
    end

    // Asynchronous reset asserted mid-cycle.
    cnt_before = cnt;
    check("pre_reset.count_nonzero", 64'(cnt_before != 0), 64'(bus.stall_count != 0));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_zero("reset_mid");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    set_instr(1, 5'd1, 5'd2, 5'd3, CTRL_ADD, 0);
    step("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
